gpo_pad_ctrl: RTL and testbench
===============================

# gpo_pad_ctrl

Digital controller that sits directly upstream of the EG 1.8 V GPO pad cell in the pad ring. It drives every core-side pad pin (DO, DS, SR, CO, OE, ODP, ODN) from a registered copy of the core's output request. It applies drive-strength, slew and mode changes glitch-free by tristating the pad around each reconfiguration. It holds drive strength at 00 until the pad's VBIAS supply is reported ready.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles OE_O is held low before and after a config update; legal range 1..255.
- CNT_W, 8, settle counter width.

Ports:
- CLK_I  in  1  sole clock
- RST_I  in  1  reset, asynchronous, active-high
- do_i  in  1  core output data
- oe_i  in  1  core output enable
- cfg_valid_i  in  1  config request valid
- cfg_ready_o  out  1  config request accepted when valid&ready
- ds_req_i  in  2  requested drive strength
- sr_req_i  in  1  requested slew rate
- co_req_i  in  1  requested CO setting
- od_mode_i  in  2  00 push-pull, 01 open-drain, 10 open-source, 11 treated as 00
- bias_ok_i  in  1  VBIAS ready, asynchronous
- busy_o  out  1  reconfiguration in progress
- ds_clamped_o  out  1  requested DS≠00 but bias not ready
- DO_O, OE_O, SR_O, CO_O, ODP_O, ODN_O  out  1 each  to pad
- DS_O  out  2  to pad

## Operation
- State machine states:
  - IDLE: cfg_ready_o=1, busy_o=0.
  - QUIESCE: SETTLE_CYCLES cycles.
  - APPLY: 1 cycle.
  - RESUME: SETTLE_CYCLES cycles.
- Transitions:
  - Accept (IDLE with cfg_valid_i high) and oe_i=1: go to QUIESCE, then APPLY, then RESUME, then IDLE.
  - Accept with oe_i=0: go to APPLY, then IDLE; the quiesce and resume phases are skipped.
- Request fields are captured on accept. The config registers (ds_cfg, SR_O, CO_O, ODP_O, ODN_O) load at the end of APPLY.
- Mode decode:
  - od_mode 01: ODP_O=1, ODN_O=0.
  - od_mode 10: ODP_O=0, ODN_O=1.
  - Otherwise: both 0.
- DO_O is registered from do_i every cycle regardless of state.
- OE_O is registered from (oe_i && next_state==IDLE). It is 0 throughout a reconfiguration, and oe_i changes during reconfiguration are ignored until IDLE.
- Bias handling:
  - bias_ok_i passes through a 2-flop synchroniser (reset 0) to produce bias_s.
  - DS_O is registered as bias_s ? ds_cfg : 00.
  - ds_clamped_o is registered as (ds_cfg≠00 && !bias_s).
  - If bias is lost while OE_O=1, DS_O drops to 00 without a quiesce; this is the intended behaviour.
- Settle counter:
  - Counts 0..SETTLE_CYCLES-1 in QUIESCE and again in RESUME.
  - Cleared on every state entry.
  - Never wraps.
- Reset (at any time, including mid-reconfiguration):
  - FSM returns to IDLE.
  - Captured request is discarded.
  - Config returns to 00 / push-pull.

## Timing
- Reset values:
  - DO_O, OE_O, SR_O, CO_O, ODP_O, ODN_O, busy_o, ds_clamped_o = 0.
  - DS_O = 00.
  - cfg_ready_o = 1.
- Data latency: DO_O and OE_O follow do_i and oe_i by 1 cycle in IDLE.
- Reconfiguration accepted at cycle t with oe_i=1, S = SETTLE_CYCLES:
  - OE_O=0 from t+1.
  - QUIESCE for t+1..t+S.
  - APPLY at t+S+1.
  - New config visible at t+S+2.
  - RESUME for t+S+2..t+2S+1.
  - IDLE at t+2S+2; cfg_ready_o=1 and OE_O=oe_i at t+2S+2.
- Reconfiguration accepted at cycle t with oe_i=0:
  - APPLY at t+1.
  - New config visible and cfg_ready_o=1 at t+2.
- Back-to-back requests: the next accept can occur in the first IDLE cycle.
- Bias latency: DS_O reflects a bias_ok_i edge 3 cycles later (2 synchroniser cycles + 1 output register).
- Simultaneous events:
  - cfg_valid_i and an oe_i rise in the same IDLE cycle: the oe_i value sampled that cycle selects the path.
  - Reset takes priority over everything.

## Test plan
- Reset: assert RST_I mid-cycle, with do_i=1 and oe_i=1 → all pad outputs 0 immediately, DS_O=00, cfg_ready_o=1, busy_o=0.
- Data path: oe_i=1, toggle do_i each cycle, bias_ok_i=1 → DO_O is do_i delayed 1 cycle; open-drain config (od_mode 01) → ODP_O=1, ODN_O=0.
- Live reconfiguration, S=4, oe_i=1, bias ready: accept ds_req_i=10, sr_req_i=1 at t → OE_O=0 over t+1..t+9; DS_O=10 and SR_O=1 at t+6; OE_O=1 and cfg_ready_o=1 at t+10.
- Idle reconfiguration: oe_i=0, accept ds_req_i=11 at t → DS_O=11 at t+2, busy_o=1 only at t+1, OE_O stays 0.
- Bias gating:
  - bias_ok_i=0 with ds_cfg=11 → DS_O=00, ds_clamped_o=1.
  - Raise bias_ok_i at t → DS_O=11 and ds_clamped_o=0 at t+3.
  - Drop bias_ok_i → DS_O=00 three cycles later.
- Reset during QUIESCE: accept ds_req_i=01 with oe_i=1, assert RST_I at t+2 → DS_O stays 00, FSM is in IDLE after release, and a new request is accepted on the first cycle after release.

Source files
------------

// File: rtl/gpo_pad_ctrl.sv
// Core-side controller for the 1.8 V GPO pad: registers data/enable, and applies
// drive/slew/mode changes with the pad tristated around each update.
module gpo_pad_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       do_i,
    input  logic       oe_i,
    input  logic       cfg_valid_i,
    output logic       cfg_ready_o,
    input  logic [1:0] ds_req_i,
    input  logic       sr_req_i,
    input  logic       co_req_i,
    input  logic [1:0] od_mode_i,
    input  logic       bias_ok_i,
    output logic       busy_o,
    output logic       ds_clamped_o,
    output logic       DO_O,
    output logic       OE_O,
    output logic [1:0] DS_O,
    output logic       SR_O,
    output logic       CO_O,
    output logic       ODP_O,
    output logic       ODN_O
);

    typedef enum logic [1:0] {IDLE, QUIESCE, APPLY, RESUME} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, load_cfg;

    logic       live_req_q, live_req_d;
    logic [1:0] ds_req_q, ds_req_d;
    logic       sr_req_q, sr_req_d;
    logic       co_req_q, co_req_d;
    logic [1:0] od_req_q, od_req_d;

    logic [1:0] ds_cfg_q, ds_cfg_d;
    logic       sr_q, sr_d;
    logic       co_q, co_d;
    logic       odp_q, odp_d;
    logic       odn_q, odn_d;

    logic       bias_meta_q, bias_s_q;
    logic       do_q, do_d;
    logic       oe_q, oe_d;
    logic [1:0] ds_out_q, ds_out_d;
    logic       clamped_q, clamped_d;

    // Returns {ODP, ODN}; mode 11 falls back to push-pull.
    function automatic logic [1:0] od_decode(input logic [1:0] mode);
        case (mode)
            2'b01:   od_decode = 2'b10;
            2'b10:   od_decode = 2'b01;
            default: od_decode = 2'b00;
        endcase
    endfunction

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid_i) state_d = oe_i ? QUIESCE : APPLY;
            QUIESCE: if (cnt_q == CNT_LAST) state_d = APPLY;
            APPLY:   state_d = live_req_q ? RESUME : IDLE;
            RESUME:  if (cnt_q == CNT_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Cleared on each state entry and saturating at the last settle count.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if ((state_q == QUIESCE || state_q == RESUME) && cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        cfg_ready_o = (state_q == IDLE);
        busy_o      = (state_q != IDLE);
        accept      = (state_q == IDLE) && cfg_valid_i;
        load_cfg    = (state_q == APPLY);
    end

    always_comb begin
        live_req_d = accept ? oe_i      : live_req_q;
        ds_req_d   = accept ? ds_req_i  : ds_req_q;
        sr_req_d   = accept ? sr_req_i  : sr_req_q;
        co_req_d   = accept ? co_req_i  : co_req_q;
        od_req_d   = accept ? od_mode_i : od_req_q;

        ds_cfg_d       = load_cfg ? ds_req_q : ds_cfg_q;
        sr_d           = load_cfg ? sr_req_q : sr_q;
        co_d           = load_cfg ? co_req_q : co_q;
        {odp_d, odn_d} = load_cfg ? od_decode(od_req_q) : {odp_q, odn_q};

        // Output stage looks at the next config so a new setting appears the cycle after APPLY.
        do_d      = do_i;
        oe_d      = oe_i && (state_d == IDLE);
        ds_out_d  = bias_s_q ? ds_cfg_d : 2'b00;
        clamped_d = (ds_cfg_d != 2'b00) && !bias_s_q;
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            live_req_q  <= 1'b0;
            ds_req_q    <= 2'b00;
            sr_req_q    <= 1'b0;
            co_req_q    <= 1'b0;
            od_req_q    <= 2'b00;
            ds_cfg_q    <= 2'b00;
            sr_q        <= 1'b0;
            co_q        <= 1'b0;
            odp_q       <= 1'b0;
            odn_q       <= 1'b0;
            bias_meta_q <= 1'b0;
            bias_s_q    <= 1'b0;
            do_q        <= 1'b0;
            oe_q        <= 1'b0;
            ds_out_q    <= 2'b00;
            clamped_q   <= 1'b0;
        end else begin
            live_req_q  <= live_req_d;
            ds_req_q    <= ds_req_d;
            sr_req_q    <= sr_req_d;
            co_req_q    <= co_req_d;
            od_req_q    <= od_req_d;
            ds_cfg_q    <= ds_cfg_d;
            sr_q        <= sr_d;
            co_q        <= co_d;
            odp_q       <= odp_d;
            odn_q       <= odn_d;
            bias_meta_q <= bias_ok_i;
            bias_s_q    <= bias_meta_q;
            do_q        <= do_d;
            oe_q        <= oe_d;
            ds_out_q    <= ds_out_d;
            clamped_q   <= clamped_d;
        end
    end

    assign DO_O         = do_q;
    assign OE_O         = oe_q;
    assign DS_O         = ds_out_q;
    assign SR_O         = sr_q;
    assign CO_O         = co_q;
    assign ODP_O        = odp_q;
    assign ODN_O        = odn_q;
    assign ds_clamped_o = clamped_q;

endmodule

// File: tb/tb_gpo_pad_ctrl.sv
// Directed bench for gpo_pad_ctrl: expectations are queued with a due cycle
// and compared against the pad outputs when that cycle is reached.
module tb_gpo_pad_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       do_i, oe_i, cfg_valid_i, cfg_ready_o;
    logic [1:0] ds_req_i;
    logic       sr_req_i, co_req_i;
    logic [1:0] od_mode_i;
    logic       bias_ok_i, busy_o, ds_clamped_o;
    logic       DO_O, OE_O, SR_O, CO_O, ODP_O, ODN_O;
    logic [1:0] DS_O;

    always #5 clk = ~clk;

    gpo_pad_ctrl #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .CLK_I(clk), .RST_I(rst), .do_i(do_i), .oe_i(oe_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .ds_req_i(ds_req_i), .sr_req_i(sr_req_i), .co_req_i(co_req_i),
        .od_mode_i(od_mode_i), .bias_ok_i(bias_ok_i), .busy_o(busy_o),
        .ds_clamped_o(ds_clamped_o), .DO_O(DO_O), .OE_O(OE_O), .DS_O(DS_O),
        .SR_O(SR_O), .CO_O(CO_O), .ODP_O(ODP_O), .ODN_O(ODN_O)
    );

    localparam logic [10:0] M_RDY  = 11'h400;
    localparam logic [10:0] M_BUSY = 11'h200;
    localparam logic [10:0] M_CLP  = 11'h100;
    localparam logic [10:0] M_DO   = 11'h080;
    localparam logic [10:0] M_OE   = 11'h040;
    localparam logic [10:0] M_DS   = 11'h030;
    localparam logic [10:0] M_SR   = 11'h008;
    localparam logic [10:0] M_CO   = 11'h004;
    localparam logic [10:0] M_ODP  = 11'h002;
    localparam logic [10:0] M_ODN  = 11'h001;
    localparam logic [10:0] M_ALL  = 11'h7FF;

    typedef struct {
        string       tag;
        int          due;
        logic [10:0] val;
        logic [10:0] mask;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [10:0] dsv(input logic [1:0] d);
        return {5'b0, d, 4'b0};
    endfunction

    function automatic logic [10:0] obs();
        return {cfg_ready_o, busy_o, ds_clamped_o, DO_O, OE_O, DS_O, SR_O, CO_O, ODP_O, ODN_O};
    endfunction

    task automatic push(input string tag, input int due, input logic [10:0] val, input logic [10:0] mask);
        exp_t e;
        e.tag  = tag;
        e.due  = due;
        e.val  = val;
        e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check_due();
        int          i = 0;
        logic [10:0] o;
        o = obs();
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                n_checks++;
                assert ((o & sb[i].mask) === (sb[i].val & sb[i].mask)) else begin
                    n_errors++;
                    $error("FAIL %s cycle %0d: observed %b expected %b (mask %b)",
                           sb[i].tag, cyc, o & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_due();
    endtask

    task automatic check_now(input string tag, input logic [10:0] val, input logic [10:0] mask);
        push(tag, cyc, val, mask);
        check_due();
    endtask

    initial begin
        int t, t2, r, b;
        rst = 1'b1;
        do_i = 1'b0; oe_i = 1'b0; cfg_valid_i = 1'b0;
        ds_req_i = 2'b00; sr_req_i = 1'b0; co_req_i = 1'b0; od_mode_i = 2'b00;
        bias_ok_i = 1'b1;
        tick();
        tick();
        check_now("reset_state", M_RDY, M_ALL);
        rst = 1'b0;

        // Data path: DO_O/OE_O follow inputs one cycle later
        oe_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            do_i = k[0];
            push("data_do_oe", cyc + 1, (k[0] ? M_DO : 11'h0) | M_OE, M_DO | M_OE);
            tick();
        end

        // Live reconfiguration with oe_i=1: DS=10, SR=1, open-drain
        t = cyc;
        cfg_valid_i = 1'b1; ds_req_i = 2'b10; sr_req_i = 1'b1; co_req_i = 1'b0; od_mode_i = 2'b01;
        do_i = 1'b1;
        check_now("live_accept_ready", M_RDY, M_RDY | M_BUSY);
        for (int d = 1; d <= 9; d++) push("live_oe_low", t + d, M_BUSY, M_OE | M_BUSY | M_RDY);
        push("live_do_follows", t + 1, M_DO, M_DO);
        push("live_old_cfg", t + 5, 11'h0, M_DS | M_SR | M_ODP);
        push("live_new_cfg", t + 6, dsv(2'b10) | M_SR | M_ODP, M_DS | M_SR | M_CO | M_ODP | M_ODN);
        push("live_done", t + 10, M_RDY | M_OE | dsv(2'b10) | M_SR | M_ODP,
             M_RDY | M_BUSY | M_OE | M_DS | M_SR | M_ODP);
        tick();
        cfg_valid_i = 1'b0;
        while (cyc < t + 10) begin
            if (cyc == t + 3) oe_i = 1'b0;
            if (cyc == t + 4) oe_i = 1'b1;
            tick();
        end

        // Idle reconfiguration with oe_i=0: DS=11, CO=1, open-source
        oe_i = 1'b0;
        push("idle_oe_off", cyc + 1, 11'h0, M_OE);
        tick();
        t = cyc;
        cfg_valid_i = 1'b1; ds_req_i = 2'b11; sr_req_i = 1'b0; co_req_i = 1'b1; od_mode_i = 2'b10;
        push("idle_apply", t + 1, M_BUSY | dsv(2'b10) | M_SR | M_ODP,
             M_RDY | M_BUSY | M_OE | M_DS | M_SR | M_ODP);
        push("idle_new_cfg", t + 2, M_RDY | dsv(2'b11) | M_CO | M_ODN,
             M_RDY | M_BUSY | M_OE | M_DS | M_SR | M_CO | M_ODP | M_ODN);
        tick();
        cfg_valid_i = 1'b0;
        tick();

        // Back-to-back accept in the first IDLE cycle; mode 11 decodes as push-pull
        t2 = cyc;
        cfg_valid_i = 1'b1; ds_req_i = 2'b11; co_req_i = 1'b0; od_mode_i = 2'b11;
        push("b2b_apply", t2 + 1, M_BUSY | dsv(2'b11) | M_CO | M_ODN, M_RDY | M_BUSY | M_DS | M_CO | M_ODN);
        push("b2b_new_cfg", t2 + 2, M_RDY | dsv(2'b11),
             M_RDY | M_BUSY | M_OE | M_DS | M_CO | M_ODP | M_ODN);
        tick();
        cfg_valid_i = 1'b0;
        tick();

        // Bias gating: three-cycle latency on DS_O and clamp flag
        b = cyc;
        bias_ok_i = 1'b0;
        push("bias_drop_early", b + 2, dsv(2'b11), M_DS | M_CLP);
        push("bias_drop_clamp", b + 3, M_CLP, M_DS | M_CLP);
        repeat (4) tick();
        b = cyc;
        bias_ok_i = 1'b1;
        push("bias_rise_early", b + 2, M_CLP, M_DS | M_CLP);
        push("bias_rise_release", b + 3, dsv(2'b11), M_DS | M_CLP);
        repeat (4) tick();
        b = cyc;
        bias_ok_i = 1'b0;
        push("bias_redrop_early", b + 2, dsv(2'b11), M_DS);
        push("bias_redrop", b + 3, M_CLP, M_DS | M_CLP);
        repeat (4) tick();
        bias_ok_i = 1'b1;
        push("bias_restore", cyc + 3, dsv(2'b11), M_DS | M_CLP);
        repeat (4) tick();

        // Reset during QUIESCE, applied mid-cycle with do_i=1 and oe_i=1
        oe_i = 1'b1; do_i = 1'b1;
        push("pre_reset_oe", cyc + 1, M_OE | M_DO, M_OE | M_DO);
        tick();
        cfg_valid_i = 1'b1; ds_req_i = 2'b01; sr_req_i = 1'b1; co_req_i = 1'b1; od_mode_i = 2'b01;
        tick();
        cfg_valid_i = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_async", M_RDY, M_ALL);
        tick();
        rst = 1'b0;
        r = cyc;
        check_now("reset_idle_after", M_RDY, M_RDY | M_BUSY | M_DS);
        cfg_valid_i = 1'b1; ds_req_i = 2'b01; sr_req_i = 1'b0; co_req_i = 1'b1; od_mode_i = 2'b10;
        for (int d = 1; d <= 5; d++) push("post_reset_ds_hold", r + d, M_BUSY, M_DS | M_BUSY);
        push("post_reset_new_cfg", r + 6, dsv(2'b01) | M_CO | M_ODN, M_DS | M_SR | M_CO | M_ODP | M_ODN);
        push("post_reset_done", r + 10, M_RDY | M_OE | M_DO | dsv(2'b01),
             M_RDY | M_BUSY | M_OE | M_DO | M_DS);
        tick();
        cfg_valid_i = 1'b0;
        while (cyc < r + 10) tick();
        tick();

        n_checks++;
        assert (sb.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
